ram_access_controller: RTL and testbench

//  Request/response front-end that drives the single-port synchronous RAM (clock, address,

---
 rtl/ram_access_controller_if.sv | 45 ++++
 rtl/ram_access_controller.sv | 130 +++++++++++++
 tb/tb_ram_access_controller.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_controller_if.sv
// Request, response and RAM-port bundle for ram_access_controller; slave = controller view.
// Latency: none (wiring only). CLEAR_SWEEP_EN adds clear_req/clear_done.
// Backpressure: req_ready/rsp_ready carry flow control in both directions.
interface ram_access_controller_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_read_or_write;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;
`ifdef CLEAR_SWEEP_EN
    logic                  clear_req;
    logic                  clear_done;
`endif

    modport slave (
`ifdef CLEAR_SWEEP_EN
        input  clear_req,
        output clear_done,
`endif
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_data_out,
        output req_ready, rsp_valid, rsp_rdata, req_err, ram_address, ram_read_or_write,
               ram_data_in
    );

    modport master (
`ifdef CLEAR_SWEEP_EN
        output clear_req,
        input  clear_done,
`endif
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_data_out,
        input  req_ready, rsp_valid, rsp_rdata, req_err, ram_address, ram_read_or_write,
               ram_data_in
    );
endinterface

// File: rtl/ram_access_controller.sv
// ram_access_controller: valid/ready front-end for a single-port sync RAM, all RAM-side outputs registered.
// Latency: a write holds the port 2 cycles; read data is valid after the 2nd edge following acceptance.
// Backpressure: req_ready low while busy or while a response awaits rsp_ready. CLEAR_SWEEP_EN adds a zero-fill sweep.
module ram_access_controller #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    ram_access_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP
`ifdef CLEAR_SWEEP_EN
        , CLR
`endif
    } state_t;

    state_t                state_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  req_err_q;
    logic [ADDR_WIDTH-1:0] ram_address_q;
    logic                  ram_rw_q;
    logic [DATA_WIDTH-1:0] ram_data_in_q;
    logic                  idle_free;
    logic                  req_fire;
    logic                  addr_ok;

    assign idle_free = (state_q == IDLE) && !rsp_valid_q;

`ifdef CLEAR_SWEEP_EN
    logic clear_done_q;
    logic clear_go;
    // A clear request outranks a pending request, so it also masks req_ready.
    assign clear_go       = idle_free && bus.clear_req;
    assign bus.req_ready  = idle_free && !bus.clear_req;
    assign bus.clear_done = clear_done_q;
`else
    assign bus.req_ready  = idle_free;
`endif

    assign req_fire = bus.req_valid && bus.req_ready;
    assign addr_ok  = 32'(bus.req_addr) < 32'(DEPTH);

    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_rdata         = rsp_rdata_q;
    assign bus.req_err           = req_err_q;
    assign bus.ram_address       = ram_address_q;
    assign bus.ram_read_or_write = ram_rw_q;
    assign bus.ram_data_in       = ram_data_in_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            req_err_q     <= 1'b0;
            ram_address_q <= '0;
            ram_rw_q      <= 1'b0;
            ram_data_in_q <= '0;
`ifdef CLEAR_SWEEP_EN
            clear_done_q  <= 1'b0;
`endif
        end else begin
            req_err_q <= 1'b0;
`ifdef CLEAR_SWEEP_EN
            clear_done_q <= 1'b0;
`endif
            if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    ram_rw_q <= 1'b0;
`ifdef CLEAR_SWEEP_EN
                    if (clear_go) begin
                        state_q       <= CLR;
                        ram_address_q <= '0;
                        ram_data_in_q <= '0;
                        ram_rw_q      <= 1'b1;
                    end else
`endif
                    if (req_fire) begin
                        if (!addr_ok) begin
                            req_err_q <= 1'b1;
                        end else begin
                            ram_address_q <= bus.req_addr;
                            ram_data_in_q <= bus.req_wdata;
                            ram_rw_q      <= bus.req_write;
                            state_q       <= bus.req_write ? WR : RD;
                        end
                    end
                end
                WR: begin
                    ram_rw_q <= 1'b0;
                    state_q  <= IDLE;
                end
                RD: begin
                    state_q <= CAP;
                end
                // RAM registered data_out on the previous edge; it is valid now.
                CAP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= bus.ram_data_out;
                    state_q     <= IDLE;
                end
`ifdef CLEAR_SWEEP_EN
                CLR: begin
                    if (ram_address_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        ram_rw_q     <= 1'b0;
                        clear_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        ram_address_q <= ram_address_q + ADDR_WIDTH'(1);
                    end
                end
`endif
                default: begin
                    ram_rw_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: RAM model, cycle-indexed reference model, per-cycle compare.
// Directed scenarios plus a randomized phase with random response backpressure.
module tb_ram_access_controller;
    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   rnd_rsp;

    ram_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    ram_access_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read data.
    logic [DW-1:0] ram_mem [0:DEPTH-1];
    logic [DW-1:0] ram_q;
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_read_or_write) ram_mem[bus.ram_address[2:0]] <= bus.ram_data_in;
        ram_q <= ram_mem[bus.ram_address[2:0]];
    end
    assign bus.ram_data_out = ram_q;

    // Reference model: every event is a cycle number derived from the acceptance cycle.
    int            cyc = 0;
    int            free_at = 0;
    int            err_cyc = -100;
    int            wr_cyc = -100;
    int            rsp_cyc = -100;
    int            clr_start = -100;
    int            done_cyc = -100;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rsp_val;
    bit            m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_mem [0:DEPTH-1];
    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    function automatic bit clr_in();
`ifdef CLEAR_SWEEP_EN
        return bus.clear_req;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rv = 1'b0; m_rd = '0; free_at = 0;
            err_cyc = -100; wr_cyc = -100; rsp_cyc = -100; clr_start = -100; done_cyc = -100;
        end else begin
            automatic int  cur   = cyc;
            automatic bit  idle  = (cur >= free_at) && !m_rv;
            automatic bit  ready = idle && !clr_in();
            if (m_rv && bus.rsp_ready) m_rv = 1'b0;
            if (rsp_cyc == cur + 1) begin m_rv = 1'b1; m_rd = rsp_val; end
            if (idle && clr_in()) begin
                clr_start = cur + 1;
                done_cyc  = cur + 1 + DEPTH;
                free_at   = cur + 1 + DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else if (ready && bus.req_valid) begin
                if (int'(bus.req_addr) >= DEPTH) begin
                    err_cyc = cur + 1;
                end else if (bus.req_write) begin
                    wr_cyc = cur + 1; wa = bus.req_addr; wd = bus.req_wdata;
                    m_mem[bus.req_addr[2:0]] = bus.req_wdata;
                    free_at = cur + 2;
                end else begin
                    rsp_cyc = cur + 3;
                    rsp_val = m_mem[bus.req_addr[2:0]];
                    free_at = cur + 3;
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit in_clr = (cyc >= clr_start) && (cyc < clr_start + DEPTH);
            automatic bit e_rw   = (cyc == wr_cyc) || in_clr;
            automatic bit e_rdy  = (cyc >= free_at) && !m_rv && !clr_in();
            check("req_ready", 32'(bus.req_ready), 32'(e_rdy));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rd));
            check("req_err", 32'(bus.req_err), 32'(cyc == err_cyc));
            check("ram_rw", 32'(bus.ram_read_or_write), 32'(e_rw));
            if (e_rw) begin
                check("ram_address", 32'(bus.ram_address), in_clr ? 32'(cyc - clr_start) : 32'(wa));
                check("ram_data_in", 32'(bus.ram_data_in), in_clr ? 32'd0 : 32'(wd));
            end
`ifdef CLEAR_SWEEP_EN
            check("clear_done", 32'(bus.clear_done), 32'(cyc == done_cyc));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd_rsp) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit keep, output int acc);
        bit hs;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            hs = bus.req_ready;
            tick();
            if (hs) begin acc = cyc; break; end
        end
        if (!keep) bus.req_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            failures++;
            $display("FAIL req_timeout addr=%0h got=no_accept want=accept", a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        checks = 0; failures = 0; rnd_rsp = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
`ifdef CLEAR_SWEEP_EN
        bus.clear_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_ram_rw", 32'(bus.ram_read_or_write), 32'd0);
        check("rst_req_err", 32'(bus.req_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write then read back with exact read latency.
        do_req(1'b1, 4'd3, 4'hA, 1'b0, acc);
        do_req(1'b0, 4'd3, 4'h0, 1'b0, acc);
        check("t1_rv_e1", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t1_rv_e2", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t1_rv_done", 32'(bus.rsp_valid), 32'd1);
        check("t1_rdata", 32'(bus.rsp_rdata), 32'hA);

        // Response held under backpressure.
        do_req(1'b1, 4'd5, 4'h6, 1'b0, acc);
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 4'd5, 4'h0, 1'b0, acc);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_rv_hold", 32'(bus.rsp_valid), 32'd1);
            check("t2_rdata_hold", 32'(bus.rsp_rdata), 32'h6);
            check("t2_ready_low", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("t2_rv_clear", 32'(bus.rsp_valid), 32'd0);
        check("t2_ready_back", 32'(bus.req_ready), 32'd1);
        check("t2_rdata_keep", 32'(bus.rsp_rdata), 32'h6);

        // Back-to-back writes with req_valid held high.
        prev = -1;
        for (int a = 0; a < DEPTH; a++) begin
            do_req(1'b1, AW'(a), DW'(a), 1'b1, acc);
            if (prev >= 0) check("t3_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
        end
        bus.req_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            do_req(1'b0, AW'(a), 4'h0, 1'b0, acc);
            tick(); tick();
            check("t3_readback", 32'(bus.rsp_rdata), 32'(a));
        end

        // Out-of-range addresses are rejected without touching the RAM.
        do_req(1'b0, 4'd8, 4'h0, 1'b0, acc);
        check("t4_err_pulse", 32'(bus.req_err), 32'd1);
        check("t4_no_rw", 32'(bus.ram_read_or_write), 32'd0);
        check("t4_ready", 32'(bus.req_ready), 32'd1);
        tick();
        check("t4_err_end", 32'(bus.req_err), 32'd0);
        do_req(1'b1, 4'd12, 4'h5, 1'b0, acc);
        check("t4_err_wr", 32'(bus.req_err), 32'd1);
        check("t4_no_rw_wr", 32'(bus.ram_read_or_write), 32'd0);

        // Reset in the RD state abandons the read.
        do_req(1'b0, 4'd2, 4'h0, 1'b0, acc);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rv", 32'(bus.rsp_valid), 32'd0);
        check("t5_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("t5_addr", 32'(bus.ram_address), 32'd0);
        check("t5_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 4'd2, 4'h0, 1'b0, acc);
        tick(); tick();
        check("t5_reread", 32'(bus.rsp_rdata), 32'd2);

`ifdef CLEAR_SWEEP_EN
        begin
            int rw_cnt, done_cnt, done_at;
            for (int a = 0; a < DEPTH; a++) do_req(1'b1, AW'(a), 4'hF, 1'b0, acc);
            tick();
            bus.clear_req = 1'b1;
            tick();
            bus.clear_req = 1'b0;
            rw_cnt = 0; done_cnt = 0; done_at = -1;
            for (int i = 0; i < 12; i++) begin
                if (bus.ram_read_or_write) rw_cnt++;
                if (bus.clear_done) begin done_cnt++; done_at = i; end
                tick();
            end
            check("t6_rw_cycles", 32'(rw_cnt), 32'd8);
            check("t6_done_cnt", 32'(done_cnt), 32'd1);
            check("t6_done_at", 32'(done_at), 32'd8);
            for (int a = 0; a < DEPTH; a++) begin
                do_req(1'b0, AW'(a), 4'h0, 1'b0, acc);
                tick(); tick();
                check("t6_zero", 32'(bus.rsp_rdata), 32'd0);
            end
        end
`endif

        // Randomized traffic with random response backpressure.
        rnd_rsp = 1'b1;
        for (int i = 0; i < 250; i++) begin
            automatic bit            r_wr = 1'($urandom_range(0, 1));
            automatic logic [AW-1:0] r_a  = AW'($urandom_range(0, 11));
            automatic logic [DW-1:0] r_d  = DW'($urandom);
            do_req(r_wr, r_a, r_d, 1'b0, acc);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_rsp = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
